// File: rtl/uart_tx_buffer_pkg.sv
// Shared types and width helpers for the UART TX byte buffer.
package uart_tx_buffer_pkg;

    // Pacing FSM encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SEND    = 2'b01,
        WAIT_HI = 2'b10,
        WAIT_LO = 2'b11
    } tx_state_e;

    // Pointer width for a FIFO of the given depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO storage with registered count. Pushes while full and pops
// while empty are ignored; the caller decides what to report.
module sync_fifo_core
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned PW        = ptr_width(DEPTH),
    localparam int unsigned CW        = cnt_width(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CW-1:0]         count,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  full, do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next count: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write; no reset needed since pointers gate visibility.
    always_ff @(posedge CLK) begin
        if (!RST && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and count registers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// UART TX byte buffer: absorbs bursts from the controller and releases one byte
// per UART frame, paced by the synchronized busy flag with a timeout guard.
// Optional LEVEL output (FIFO fill count) enabled by UART_TX_BUFFER_LEVEL_EN.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TIMEOUT    = 1024,
    localparam int unsigned CW        = cnt_width(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VLD,
    output logic                  IN_RDY,
    input  logic                  UART_BUSY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VLD,
    output logic                  EMPTY,
    output logic                  OVERFLOW,
    output logic                  TIMEOUT_ERR
`ifdef UART_TX_BUFFER_LEVEL_EN
    ,
    output logic [CW-1:0]         LEVEL
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    tx_state_e             state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  overflow_q, timeout_err_q, timeout_hit;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty, pop;

    sync_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (IN_VLD),
        .push_data (IN_DATA),
        .pop       (pop),
        .pop_data  (head_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Ready comes from the registered count, so a same-cycle pop never frees a slot.
    assign fifo_full   = (fifo_count == CW'(DEPTH));
    assign IN_RDY      = ~fifo_full;
    assign EMPTY       = fifo_empty;
    assign OUT_DATA    = out_data_q;
    assign OUT_VLD     = (state_q == SEND);
    assign OVERFLOW    = overflow_q;
    assign TIMEOUT_ERR = timeout_err_q;
`ifdef UART_TX_BUFFER_LEVEL_EN
    assign LEVEL       = fifo_count;
`endif

    // Pacing FSM: pop a byte, pulse it out, then wait for busy to rise and fall.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        out_data_d  = out_data_q;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !UART_BUSY) begin
                    out_data_d = head_data;
                    pop        = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                timer_d = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (UART_BUSY) begin
                    state_d = WAIT_LO;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // UART never picked the byte up; drop it and move on.
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_LO: begin
                if (!UART_BUSY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer, output byte and error flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            out_data_q    <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            out_data_q    <= out_data_d;
            overflow_q    <= overflow_q | (IN_VLD & fifo_full);
            timeout_err_q <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer (scoreboard of expected bytes).
module tb_uart_tx_buffer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] IN_DATA = '0;
    logic       IN_VLD = 1'b0;
    logic       IN_RDY;
    logic       UART_BUSY;
    logic [7:0] OUT_DATA;
    logic       OUT_VLD;
    logic       EMPTY;
    logic       OVERFLOW;
    logic       TIMEOUT_ERR;
`ifdef UART_TX_BUFFER_LEVEL_EN
    logic [3:0] LEVEL;
`endif

    logic busy_manual = 1'b0;
    logic busy_auto   = 1'b0;
    assign UART_BUSY = busy_manual | busy_auto;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   auto_len = 0;
    int   auto_cnt = 0;
    int   vld_cnt  = 0;
    int   obs_rd   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];

    uart_tx_buffer dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_DATA     (IN_DATA),
        .IN_VLD      (IN_VLD),
        .IN_RDY      (IN_RDY),
        .UART_BUSY   (UART_BUSY),
        .OUT_DATA    (OUT_DATA),
        .OUT_VLD     (OUT_VLD),
        .EMPTY       (EMPTY),
        .OVERFLOW    (OVERFLOW),
        .TIMEOUT_ERR (TIMEOUT_ERR)
`ifdef UART_TX_BUFFER_LEVEL_EN
        ,
        .LEVEL       (LEVEL)
`endif
    );

    always #5 CLK = ~CLK;

    // Capture sends and emulate a UART that stays busy auto_len cycles per byte.
    always @(negedge CLK) begin
        if (OUT_VLD) begin
            obs_q.push_back(OUT_DATA);
            vld_cnt++;
            if (auto_len > 0) auto_cnt = auto_len;
        end
        if (auto_cnt > 0) begin
            busy_auto = 1'b1;
            auto_cnt--;
        end else begin
            busy_auto = 1'b0;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input bit accept);
        IN_DATA = d;
        IN_VLD  = 1'b1;
        if (accept) exp_q.push_back(d);
        step();
        IN_VLD  = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        IN_VLD = 1'b0;
        busy_manual = 1'b0;
        auto_len = 0;
        repeat (16) step();
        RST = 1'b0;
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        busy_manual = 1'b1;
        repeat (3) step();
        n_checks++; if (EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", EMPTY); end
        n_checks++; if (IN_RDY !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 1", IN_RDY); end
        n_checks++; if (OUT_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b want 0", OUT_VLD); end
        n_checks++; if (OUT_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", OUT_DATA); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", OVERFLOW); end
        n_checks++; if (TIMEOUT_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", TIMEOUT_ERR); end
`ifdef UART_TX_BUFFER_LEVEL_EN
        n_checks++; if (LEVEL !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", LEVEL); end
`endif
        RST = 1'b0;
        repeat (3) step();
        n_checks++; if (OUT_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_busy_idle: got %b want 0", OUT_VLD); end
    endtask

    task automatic test_single();
        int base;
        do_reset();
        write_byte(8'hA5, 1'b1);
        n_checks++; if (OUT_VLD !== 1'b0) begin n_fail++; $display("FAIL single_cyc1: got %b want 0", OUT_VLD); end
        step();
        n_checks++; if (OUT_VLD !== 1'b1) begin n_fail++; $display("FAIL single_cyc2_vld: got %b want 1", OUT_VLD); end
        n_checks++; if (OUT_DATA !== 8'hA5) begin n_fail++; $display("FAIL single_cyc2_data: got %h want a5", OUT_DATA); end
        busy_manual = 1'b1;
        write_byte(8'h5A, 1'b1);
        base = vld_cnt;
        repeat (19) step();
        n_checks++; if (vld_cnt !== base) begin n_fail++; $display("FAIL single_wait_busy: got %0d sends want %0d", vld_cnt, base); end
        busy_manual = 1'b0;
        for (int i = 0; i < 10 && vld_cnt < base + 1; i++) step();
        n_checks++; if (vld_cnt !== base + 1) begin n_fail++; $display("FAIL single_second_send: got %0d want %0d", vld_cnt, base + 1); end
        n_checks++; if (OUT_DATA !== 8'h5A) begin n_fail++; $display("FAIL single_held: got %h want 5a", OUT_DATA); end
        n_checks++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_fail++; $display("FAIL single_n: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            logic [7:0] e = exp_q.pop_front();
            n_checks++;
            if (obs_q[obs_rd] !== e) begin n_fail++; $display("FAIL single_order: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
    endtask

    task automatic test_burst();
        int base;
        do_reset();
        busy_manual = 1'b1;
        for (int i = 1; i <= 8; i++) write_byte(8'(i), 1'b1);
        n_checks++; if (EMPTY !== 1'b0) begin n_fail++; $display("FAIL burst_empty: got %b want 0", EMPTY); end
        n_checks++; if (IN_RDY !== 1'b0) begin n_fail++; $display("FAIL burst_in_rdy: got %b want 0", IN_RDY); end
        base = vld_cnt;
        auto_len = 10;
        busy_manual = 1'b0;
        for (int i = 0; i < 400 && vld_cnt < base + 8; i++) step();
        repeat (40) step();
        n_checks++; if (vld_cnt !== base + 8) begin n_fail++; $display("FAIL burst_pulses: got %0d want %0d", vld_cnt - base, 8); end
        n_checks++; if (EMPTY !== 1'b1) begin n_fail++; $display("FAIL burst_drained: got %b want 1", EMPTY); end
        n_checks++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_fail++; $display("FAIL burst_n: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            logic [7:0] e = exp_q.pop_front();
            n_checks++;
            if (obs_q[obs_rd] !== e) begin n_fail++; $display("FAIL burst_order: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        busy_manual = 1'b1;
        for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i), 1'b1);
        write_byte(8'hFF, 1'b0);
        n_checks++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", OVERFLOW); end
        n_checks++; if (IN_RDY !== 1'b0) begin n_fail++; $display("FAIL ovf_still_full: got %b want 0", IN_RDY); end
        repeat (5) step();
        n_checks++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); end
        base = vld_cnt;
        auto_len = 10;
        busy_manual = 1'b0;
        for (int i = 0; i < 400 && vld_cnt < base + 8; i++) step();
        repeat (40) step();
        n_checks++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drain: got %b want 1", OVERFLOW); end
        n_checks++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_fail++; $display("FAIL ovf_n: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            logic [7:0] e = exp_q.pop_front();
            n_checks++;
            if (obs_q[obs_rd] !== e) begin n_fail++; $display("FAIL ovf_order: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
        RST = 1'b1;
        step();
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf_reset: got %b want 0", OVERFLOW); end
        RST = 1'b0;
    endtask

    task automatic test_timeout();
        int base;
        int n;
        do_reset();
        busy_manual = 1'b1;
        write_byte(8'h3C, 1'b1);
        write_byte(8'h3D, 1'b1);
        base = vld_cnt;
        busy_manual = 1'b0;
        for (int i = 0; i < 10 && OUT_VLD !== 1'b1; i++) step();
        n_checks++; if (OUT_VLD !== 1'b1) begin n_fail++; $display("FAIL to_first_vld: got %b want 1", OUT_VLD); end
        n_checks++; if (OUT_DATA !== 8'h3C) begin n_fail++; $display("FAIL to_first_data: got %h want 3c", OUT_DATA); end
        // SEND is at n=0, WAIT_HI entry at n=1, pulse due 1024 cycles later.
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            n++;
            if (n == 1) auto_len = 10;
            if (TIMEOUT_ERR === 1'b1) break;
        end
        n_checks++; if (n !== 1025) begin n_fail++; $display("FAIL to_latency: got %0d want 1025", n); end
        step();
        n_checks++; if (TIMEOUT_ERR !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", TIMEOUT_ERR); end
        for (int i = 0; i < 20 && vld_cnt < base + 2; i++) step();
        repeat (20) step();
        n_checks++; if (vld_cnt !== base + 2) begin n_fail++; $display("FAIL to_next_send: got %0d want %0d", vld_cnt - base, 2); end
        n_checks++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_fail++; $display("FAIL to_n: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            logic [7:0] e = exp_q.pop_front();
            n_checks++;
            if (obs_q[obs_rd] !== e) begin n_fail++; $display("FAIL to_order: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
    endtask

    task automatic test_simul_push_pop();
        int base;
        do_reset();
        busy_manual = 1'b1;
        auto_len = 10;
        base = vld_cnt;
        write_byte(8'h77, 1'b1);
        step();
        // Busy drops in the same cycle the new byte arrives: pop and push together.
        busy_manual = 1'b0;
        write_byte(8'h55, 1'b1);
        n_checks++; if (OUT_VLD !== 1'b1) begin n_fail++; $display("FAIL simul_vld: got %b want 1", OUT_VLD); end
        n_checks++; if (OUT_DATA !== 8'h77) begin n_fail++; $display("FAIL simul_data: got %h want 77", OUT_DATA); end
        n_checks++; if (EMPTY !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got %b want 0", EMPTY); end
        n_checks++; if (IN_RDY !== 1'b1) begin n_fail++; $display("FAIL simul_in_rdy: got %b want 1", IN_RDY); end
`ifdef UART_TX_BUFFER_LEVEL_EN
        n_checks++; if (LEVEL !== 4'd1) begin n_fail++; $display("FAIL simul_level: got %0d want 1", LEVEL); end
`endif
        for (int i = 0; i < 100 && vld_cnt < base + 2; i++) step();
        n_checks++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_fail++; $display("FAIL simul_n: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            logic [7:0] e = exp_q.pop_front();
            n_checks++;
            if (obs_q[obs_rd] !== e) begin n_fail++; $display("FAIL simul_order: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
    endtask

    task automatic test_reset_mid_send();
        int base;
        do_reset();
        busy_manual = 1'b1;
        write_byte(8'hB1, 1'b1);
        write_byte(8'hB2, 1'b0);
        write_byte(8'hB3, 1'b0);
        write_byte(8'hB4, 1'b0);
        busy_manual = 1'b0;
        step();
        busy_manual = 1'b1;
        n_checks++; if (OUT_VLD !== 1'b1) begin n_fail++; $display("FAIL mid_send_vld: got %b want 1", OUT_VLD); end
        step();
        step();
`ifdef UART_TX_BUFFER_LEVEL_EN
        n_checks++; if (LEVEL !== 4'd3) begin n_fail++; $display("FAIL mid_level3: got %0d want 3", LEVEL); end
`endif
        RST = 1'b1;
        step();
        n_checks++; if (OUT_VLD !== 1'b0) begin n_fail++; $display("FAIL mid_out_vld: got %b want 0", OUT_VLD); end
        n_checks++; if (EMPTY !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b want 1", EMPTY); end
        n_checks++; if (OUT_DATA !== 8'h00) begin n_fail++; $display("FAIL mid_out_data: got %h want 00", OUT_DATA); end
`ifdef UART_TX_BUFFER_LEVEL_EN
        n_checks++; if (LEVEL !== 4'd0) begin n_fail++; $display("FAIL mid_level0: got %0d want 0", LEVEL); end
`endif
        RST = 1'b0;
        busy_manual = 1'b0;
        base = vld_cnt;
        repeat (40) step();
        n_checks++; if (vld_cnt !== base) begin n_fail++; $display("FAIL mid_no_sends: got %0d want 0", vld_cnt - base); end
        n_checks++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_fail++; $display("FAIL mid_n: got %0d want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            logic [7:0] e = exp_q.pop_front();
            n_checks++;
            if (obs_q[obs_rd] !== e) begin n_fail++; $display("FAIL mid_order: got %h want %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
    endtask

    initial begin
        step();
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_timeout();
        test_simul_push_pop();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Single-clock byte buffer and pacing stage in the REF_CLK domain.
- Sits between the system controller's TX byte output (data/valid pulse) and the TX data synchronizer feeding the UART transmitter.
- Absorbs multi-byte bursts, such as two-byte ALU results and read responses, in a FIFO.
- Releases one byte per UART frame, paced by the synchronized UART busy flag, with a timeout guard.

Parameters:
- DATA_WIDTH, 8, byte width.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- TIMEOUT, 1024, max CLK cycles to wait for UART_BUSY to rise after a send; >= 2.

Ports:
- CLK  in  1  system reference clock.
- RST  in  1  synchronous active-high reset.
- IN_DATA  in  DATA_WIDTH  byte from system controller.
- IN_VLD  in  1  one-cycle write strobe.
- IN_RDY  out  1  high when FIFO not full.
- UART_BUSY  in  1  synchronized UART TX busy.
- OUT_DATA  out  DATA_WIDTH  byte to TX data synchronizer; held stable between sends.
- OUT_VLD  out  1  one-cycle send pulse.
- EMPTY  out  1  FIFO empty.
- OVERFLOW  out  1  sticky; a write was dropped.
- TIMEOUT_ERR  out  1  one-cycle pulse; busy never rose after a send.

Behaviour:
- Reset (synchronous, active-high; the only clock is CLK, the only reset is RST):
  - Pointers and count cleared.
  - State IDLE.
  - OUT_DATA = 0, OUT_VLD = 0, OVERFLOW = 0, TIMEOUT_ERR = 0, EMPTY = 1, IN_RDY = 1.
  - Reset mid-operation discards all buffered bytes and the in-flight send.
- Write: IN_VLD & IN_RDY stores IN_DATA at wr_ptr, wr_ptr++, wrapping modulo DEPTH.
- Full write: IN_VLD while full drops the byte, sets OVERFLOW, and leaves the FIFO unchanged.
  - IN_RDY is derived from the current-cycle registered count.
  - A pop in the same cycle does not make room for a write in that cycle.
- Count: simultaneous push and pop leaves count unchanged. Count range 0..DEPTH, width clog2(DEPTH)+1.
- FSM states:
  - IDLE: if !EMPTY & !UART_BUSY, load OUT_DATA with the head byte, rd_ptr++, go to SEND. Otherwise stay.
  - SEND: OUT_VLD = 1 for exactly this cycle; clear timer; go to WAIT_HI.
  - WAIT_HI: if UART_BUSY, go to WAIT_LO. Else if timer == TIMEOUT-1, pulse TIMEOUT_ERR and go to IDLE; the byte is considered lost, with no retry. Else timer++.
  - WAIT_LO: if !UART_BUSY, go to IDLE.
- Latency: IN_VLD into an empty FIFO (cycle 0) with UART idle gives OUT_VLD in cycle 2.
- Minimum spacing between OUT_VLD pulses: 4 cycles plus the busy duration.
- Ordering: strict FIFO order; no byte is ever duplicated.
- Busy at entry: UART_BUSY high while in IDLE (for example, after reset) blocks sending until it falls.
- Write while the FSM is in SEND/WAIT: accepted normally if not full.

Optional Feature:
- Macro: UART_TX_BUFFER_LEVEL_EN.
- Defined: adds output port LEVEL, width clog2(DEPTH)+1, equal to the registered FIFO count (0..DEPTH), reset 0.
- Undefined: no LEVEL port and no extra logic. All other behaviour is identical.

Decomposition:
- Shared package uart_tx_buffer_pkg:
  - FSM state encoding constants: IDLE = 2'b00, SEND = 2'b01, WAIT_HI = 2'b10, WAIT_LO = 2'b11.
  - Pointer/count width helper derived from DEPTH.
- One sub-module, sync_fifo_core:
  - Storage array, read/write pointers, count, full/empty.
  - Push/pop inputs.
  - Same CLK/RST convention.
- The top level holds the FSM, timeout counter, OUT_DATA register and error flags.

Test Plan:
- Single byte: RST released, UART_BUSY = 0; IN_DATA = 8'hA5 with IN_VLD in cycle 0 -> OUT_VLD in cycle 2 with OUT_DATA = 8'hA5. Bench raises UART_BUSY for 20 cycles; the next send waits for the fall.
- Burst order: write 8'h01..8'h08 back-to-back while UART_BUSY = 1 -> EMPTY = 0 and IN_RDY = 0 after the 8th. Emulate 10-cycle busy per byte -> outputs 01..08 in order, exactly 8 OUT_VLD pulses, then EMPTY = 1.
- Overflow: fill 8 bytes, then write 8'hFF while full -> OVERFLOW = 1 (sticky) and 8'hFF never appears on OUT_DATA. RST clears OVERFLOW.
- Timeout: send 8'h3C with UART_BUSY held 0 -> TIMEOUT_ERR pulses exactly 1024 cycles after the WAIT_HI entry. The next queued byte 8'h3D then sends normally.
- Simultaneous push and pop: count = 1 in IDLE, UART idle, write 8'h55 in the pop cycle -> count stays 1; 8'h55 is sent after the current byte.
- Reset mid-send: assert RST during WAIT_LO with 3 bytes queued -> next cycle OUT_VLD = 0, EMPTY = 1, OUT_DATA = 0, and no further sends. With UART_BUSY_LEVEL_EN (macro UART_TX_BUFFER_LEVEL_EN) defined, LEVEL tracks 0 -> 3 -> 0.
